// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// bounds data-memory waits with a timeout trap and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 ir_we,
  input  logic                 regWrite,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 BranchSig,
  input  logic                 Jump,
  input  logic                 SYSTEM,
  input  logic                 branch_taken,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 trap,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  // The wait counter reaches MEM_TIMEOUT on the cycle it would increment past this value.
  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] RETIRE_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_next_s;
  logic [15:0]          wait_cnt_r;
  logic [CNT_WIDTH-1:0] retired_r;
  logic                 halted_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and control-strobe decode
  always_comb begin
    state_next_s = state_r;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    trap         = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we        = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (SYSTEM) begin
          state_next_s = S_TRAP;
        end else begin
          state_next_s = S_EXEC;
        end
      end
      S_EXEC: begin
        if (MemRead || MemWrite) begin
          state_next_s = S_MEM;
        end else begin
          state_next_s = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite;
        // A late ack still completes the access even on the timeout cycle.
        if (dmem_ack) begin
          state_next_s = S_WB;
        end else if (wait_cnt_r >= TIMEOUT_LAST) begin
          state_next_s = S_TRAP;
        end else begin
          state_next_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we        = regWrite;
        pc_we        = 1'b1;
        pc_sel       = Jump | (BranchSig & branch_taken);
        state_next_s = S_FETCH;
      end
      S_TRAP: begin
        trap         = 1'b1;
        state_next_s = S_TRAP;
      end
      S_UNUSED: begin
        state_next_s = S_TRAP;
      end
      default: begin
        state_next_s = S_TRAP;
      end
    endcase
  end

  // Data-memory wait counter, cleared outside MEM so every access starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 16'd0;
    end else if ((state_r == S_MEM) && !dmem_ack) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= 16'd0;
    end
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= {CNT_WIDTH{1'b0}};
    end else if (state_r == S_WB) begin
      retired_r <= retired_r + RETIRE_ONE;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Sticky halt flag, raised together with the entry into TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (state_next_s == S_TRAP) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  assign state   = state_r;
  assign retired = retired_r;
  assign halted  = halted_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand-written
// reset, SYSTEM-trap and counter-wrap sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, imem_req, imem_ack, ir_we;
  logic       regWrite, MemRead, MemWrite, BranchSig, Jump, SYSTEM, branch_taken;
  logic       dmem_req, dmem_we, dmem_ack;
  logic       rf_we, pc_we, pc_sel, trap, halted;
  logic [2:0] state;
  logic [3:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_WIDTH(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .regWrite(regWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .BranchSig(BranchSig), .Jump(Jump), .SYSTEM(SYSTEM),
    .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .halted(halted), .state(state), .retired(retired)
  );

  // in : {start, imem_ack, regWrite, MemRead, MemWrite, BranchSig, Jump, SYSTEM, branch_taken, dmem_ack}
  // out: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap, halted}
  typedef struct {
    logic [9:0] in;
    logic [2:0] st;
    logic [8:0] out;
    logic [3:0] ret;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [9:0] in, input logic [2:0] st,
                              input logic [8:0] out, input logic [3:0] ret);
    vec_t v;
    v.in = in; v.st = st; v.out = out; v.ret = ret;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {start, imem_ack, regWrite, MemRead, MemWrite, BranchSig, Jump, SYSTEM,
     branch_taken, dmem_ack} = 10'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    // ALU op, then taken branch
    add(10'b0000000000, 3'd0, 9'b000000000, 4'd0);
    add(10'b1000000000, 3'd0, 9'b000000000, 4'd0);
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd0);
    add(10'b0010000000, 3'd2, 9'b000000000, 4'd0);
    add(10'b0010000000, 3'd3, 9'b000000000, 4'd0);
    add(10'b0010000000, 3'd5, 9'b000011000, 4'd0);
    add(10'b0000000000, 3'd1, 9'b100000000, 4'd1);
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd1);
    add(10'b0000010000, 3'd2, 9'b000000000, 4'd1);
    add(10'b0000010000, 3'd3, 9'b000000000, 4'd1);
    add(10'b0000010010, 3'd5, 9'b000001100, 4'd1);
    // not-taken branch
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd2);
    add(10'b0000010000, 3'd2, 9'b000000000, 4'd2);
    add(10'b0000010000, 3'd3, 9'b000000000, 4'd2);
    add(10'b0000010000, 3'd5, 9'b000001000, 4'd2);
    // load, ack on the 4th MEM cycle which is also the timeout cycle
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd3);
    add(10'b0011000000, 3'd2, 9'b000000000, 4'd3);
    add(10'b0011000000, 3'd3, 9'b000000000, 4'd3);
    add(10'b0011000000, 3'd4, 9'b001000000, 4'd3);
    add(10'b0011000000, 3'd4, 9'b001000000, 4'd3);
    add(10'b0011000000, 3'd4, 9'b001000000, 4'd3);
    add(10'b0011000001, 3'd4, 9'b001000000, 4'd3);
    add(10'b0011000000, 3'd5, 9'b000011000, 4'd3);
    // jump without register write
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd4);
    add(10'b0000001000, 3'd2, 9'b000000000, 4'd4);
    add(10'b0000001000, 3'd3, 9'b000000000, 4'd4);
    add(10'b0000001000, 3'd5, 9'b000001100, 4'd4);
    // store that never gets an ack: traps after 4 MEM cycles, start ignored
    add(10'b0100000000, 3'd1, 9'b110000000, 4'd5);
    add(10'b0000100000, 3'd2, 9'b000000000, 4'd5);
    add(10'b0000100000, 3'd3, 9'b000000000, 4'd5);
    add(10'b0000100000, 3'd4, 9'b001100000, 4'd5);
    add(10'b0000100000, 3'd4, 9'b001100000, 4'd5);
    add(10'b0000100000, 3'd4, 9'b001100000, 4'd5);
    add(10'b0000100000, 3'd4, 9'b001100000, 4'd5);
    add(10'b0000100000, 3'd6, 9'b000000011, 4'd5);
    add(10'b1000000000, 3'd6, 9'b000000011, 4'd5);
    add(10'b0000000000, 3'd6, 9'b000000011, 4'd5);

    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap, halted}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      {start, imem_ack, regWrite, MemRead, MemWrite, BranchSig, Jump, SYSTEM,
       branch_taken, dmem_ack} = vecs[i].in;
      #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_out", i),
          32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap, halted}),
          32'(vecs[i].out));
      chk($sformatf("v%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
      @(negedge clk);
    end
    clear_inputs();

    // asynchronous reset out of TRAP, mid high phase
    async_reset();
    chk("arst_trap_state", 32'(state), 32'd0);
    chk("arst_trap_halted", 32'(halted), 32'd0);
    chk("arst_trap_trap", 32'(trap), 32'd0);
    chk("arst_trap_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_hold", 32'(state), 32'd0);
    end

    // SYSTEM at DECODE traps without memory or register activity
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("sys_fetch_irwe", 32'(ir_we), 32'd1);
    @(negedge clk);
    imem_ack = 1'b0;
    SYSTEM = 1'b1;
    #1;
    chk("sys_decode_state", 32'(state), 32'd2);
    @(negedge clk);
    SYSTEM = 1'b0;
    #1;
    chk("sys_trap_state", 32'(state), 32'd6);
    chk("sys_trap_flags", 32'({trap, halted}), 32'd3);
    chk("sys_trap_quiet", 32'({dmem_req, rf_we, pc_we}), 32'd0);

    // reset mid-FETCH drops imem_req immediately
    async_reset();
    chk("arst_sys_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("fetch_wait_req", 32'(imem_req), 32'd1);
    async_reset();
    chk("arst_fetch_req", 32'(imem_req), 32'd0);
    chk("arst_fetch_state", 32'(state), 32'd0);

    // reset mid-MEM drops dmem_req immediately, no retire or write
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    MemRead = 1'b1;
    regWrite = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("mem_req_on", 32'(dmem_req), 32'd1);
    async_reset();
    chk("arst_mem_req", 32'(dmem_req), 32'd0);
    chk("arst_mem_wr", 32'({rf_we, pc_we}), 32'd0);
    chk("arst_mem_retired", 32'(retired), 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    // 16 ALU instructions wrap the 4-bit retired counter
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      regWrite = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("wrap%0d_wb", i), 32'({state, rf_we, pc_we}), 32'({3'd5, 1'b1, 1'b1}));
      @(negedge clk);
      regWrite = 1'b0;
      #1;
      chk($sformatf("wrap%0d_retired", i), 32'(retired), 32'(i % 16));
      chk($sformatf("wrap%0d_state", i), 32'(state), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, giving the retired-instruction counter width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum data-memory wait in cycles (range 1..65535).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: leave IDLE and begin fetching.
REQ-006 SHALL have ports imem_req (output, 1) and imem_ack (input, 1): instruction-fetch handshake.
REQ-007 SHALL have port ir_we, output, 1: instruction-register load strobe.
REQ-008 SHALL have inputs regWrite, MemRead, MemWrite, BranchSig, Jump and SYSTEM (1 each): decoder controls for the latched instruction.
REQ-009 SHALL have port branch_taken, input, 1: comparator result.
REQ-010 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1): data-memory handshake.
REQ-011 SHALL have outputs rf_we, pc_we and pc_sel (1 each); pc_sel=0 selects PC+4 and pc_sel=1 selects the branch/jump target.
REQ-012 SHALL have outputs trap (1) and halted (1): fault/stop indication.
REQ-013 SHALL have outputs state (3) and retired (CNT_WIDTH): current FSM state and count of retired instructions.

Function
REQ-014 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 is unused and SHALL go to TRAP.
REQ-015 SHALL decode all control outputs combinationally from the registered state and inputs; retired, the wait counter and halted SHALL be registered.
REQ-016 IDLE: all strobes 0; start=1 goes to FETCH on the next edge.
REQ-017 FETCH: imem_req=1 while in state; with imem_ack=1, ir_we=1 in that same cycle and next state is DECODE; otherwise remain in FETCH indefinitely.
REQ-018 DECODE: one cycle; SYSTEM=1 goes to TRAP, otherwise goes to EXEC.
REQ-019 EXEC: one cycle; MemRead or MemWrite goes to MEM, otherwise goes to WB.
REQ-020 MEM: dmem_req=1 and dmem_we=MemWrite; dmem_ack goes to WB.
REQ-021 MEM: the wait counter clears on entry and increments each cycle without ack; when the count reaches MEM_TIMEOUT without ack, next state is TRAP.
REQ-022 MEM: when ack and timeout occur in the same cycle, ack SHALL win.
REQ-023 WB: one cycle; rf_we=regWrite, pc_we=1, pc_sel=Jump|(BranchSig&branch_taken); retired increments by 1; next state is FETCH.
REQ-024 The retired counter SHALL wrap from all-ones to 0 silently.
REQ-025 TRAP: trap=1 every cycle; halted is set and sticky; all other strobes 0; the block stays in TRAP until reset, and start SHALL be ignored there.
REQ-026 imem_req and dmem_req SHALL never both be 1; rf_we and pc_we SHALL assert only in WB.
REQ-027 Latency with zero-wait acks: a non-memory instruction SHALL take 4 cycles (FETCH, DECODE, EXEC, WB) and a load/store 5 cycles.
REQ-028 Decoder inputs SHALL be sampled only in DECODE through WB; their values in other states are don't-care.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, retired=0, wait counter=0, halted=0, and all strobes plus trap to 0, independent of clk.
REQ-030 Reset asserted mid-MEM or mid-FETCH SHALL drop dmem_req/imem_req in the same cycle with no retire or write.
REQ-031 After rst_n deasserts, the block SHALL stay in IDLE until start=1 is sampled on a rising edge.

Verification
REQ-032 ALU op (regWrite=1, no memory), imem_ack immediate -> states 1,2,3,5,1; rf_we=1 and pc_we=1 in WB only; pc_sel=0; retired=1.
REQ-033 Taken branch (BranchSig=1, branch_taken=1, regWrite=0) -> WB shows pc_sel=1, rf_we=0; not-taken repeat -> pc_sel=0; retired=2.
REQ-034 Load with dmem_ack after 3 wait cycles -> MEM held 4 cycles with dmem_req=1 and dmem_we=0; then WB with rf_we=1; total 8 cycles.
REQ-035 Store with MEM_TIMEOUT=4 and ack never returned -> TRAP after 4 MEM cycles; trap=1, halted=1, retired unchanged; start pulse ignored.
REQ-036 SYSTEM=1 at DECODE -> TRAP next cycle with no dmem_req or rf_we; then rst_n=0 asynchronously mid-cycle -> state=0, halted=0 before the next edge.
REQ-037 CNT_WIDTH=4, 16 consecutive ALU instructions -> retired wraps 15 to 0.
